mem_except_ctrl: RTL
====================

// Module: mem_except_ctrl
// PURPOSE
// - MEM-stage exception controller; it is the producer side of the CP0 exception interface.
// - Collects per-instruction exception flags and the interrupt state, priority-encodes one exception code,
//   and drives m_cp0_bus into the CP0 register file.
// - Consumes cp0_bus {status,cause,epc}. Emits a one-cycle pipeline flush and a redirect PC
//   (exception vector, or EPC for eret). Tracks delay slots and blocks re-entry while CP0 updates.
// PARAMETERS
// - EXC_VECTOR   32'hBFC00380  redirect target for every exception other than eret
// - HOLD_CYCLES  1             cycles after FLUSH during which new exceptions/interrupts are masked (1..3)
// PORTS
// - clk            in   1   clock
// - rst            in   1   synchronous reset, active-high
// - mem_valid_i    in   1   MEM holds a live instruction
// - mem_stall_i    in   1   MEM stalled this cycle; instruction does not commit
// - mem_pc_i       in   32  PC of MEM instruction
// - mem_is_br_i    in   1   MEM instruction is a branch/jump (its successor is a delay slot)
// - exc_flags_i    in   7   {ov, ri, brk, sys, ades, adel_data, adel_fetch}
// - eret_i         in   1   MEM instruction is eret
// - mem_badaddr_i  in   32  faulting data address (adel_data/ades)
// - cp0_bus_i      in   96  {status[31:0], cause[31:0], epc[31:0]} from CP0
// - w_cp0_bus_i    in   38  {w_en, addr[4:0], data[31:0]} mtc0 write committed this cycle
// - m_cp0_bus_o    out  69  {badaddr[31:0], delayslot, pc[31:0], except_info[3:0]} to CP0
// - flush_o        out  1   one-cycle flush of IF..MEM
// - redirect_o     out  1   redirect_pc_o valid (same cycle as flush_o)
// - redirect_pc_o  out  32  next fetch PC
// BEHAVIOUR
// - Reset: all outputs 0; state RUN; br_q=0; hold counter 0.
// - except_info codes: 1=int, 4=AdEL, 5=AdES, 8=Sys, 9=Bp, a=RI, c=Ov, e=eret, 0=none.
// - Priority (high->low): int > adel_fetch(4, badaddr=pc) > ri > ov > sys > brk > adel_data(4) > ades(5) > eret.
// - int_pend = status[0] & ~status[1] & |(cause[15:8] & status[15:8]).
// - commit = mem_valid_i & ~mem_stall_i & (state==RUN) & (hold==0).
//   - When commit is 0, except_info=0.
//   - m_cp0_bus_o is combinational within the same cycle T; CP0 latches it at the end of T.
// - delayslot = br_q.
//   - br_q <= mem_is_br_i on every commit cycle without an exception.
//   - br_q clears on flush.
// - EPC for eret: if w_en & addr==14, the forwarded w_cp0 data; otherwise cp0_bus epc.
//   - Target is captured in cycle T.
// - FSM RUN -> FLUSH on commit & code!=0.
//   - In FLUSH (T+1): flush_o=redirect_o=1; redirect_pc_o = EXC_VECTOR, or the captured EPC when code==e.
//   - FLUSH -> HOLD (load HOLD_CYCLES) -> RUN when the counter reaches 0.
//   - In HOLD, except_info=0 and flush_o=0.
// - Stall with a pending exception: no code is sent until the stall drops; the flags are re-evaluated every cycle.
// - Interrupt and an instruction exception in the same cycle: the interrupt wins (code 1).
//   - badaddr field = mem_badaddr_i only for data AdEL/AdES, pc for fetch AdEL, otherwise 0.
// - rst asserted in FLUSH/HOLD: state returns to RUN next cycle and flush_o drops immediately.
// BEHAVIOUR (no-exception commit)
// - No side effects apart from the br_q update.
// STRUCTURE
// - Shared header Defines.vh: EXC_* code constants, CP0_Reg_* addresses, bus field widths, EXC_VECTOR default.
// - Sub-module except_prio_enc: combinational flags + int_pend -> {code[3:0], badaddr_sel}.
// - Top holds the FSM, hold counter, br_q, EPC capture.
// TESTING
// - Sys: valid pc=0x80001000, sys=1 -> T: except_info=8, pc=0x80001000, ds=0;
//   T+1: flush=redirect=1, pc=0xBFC00380.
// - Delay slot: branch commits, then adel_data @0x80001008 with badaddr=0x3 -> info=4, ds=1, badaddr=0x3.
// - Interrupt: status=0x0000FF01, cause[10]=1, plus ov on same instr -> info=1 (ov dropped).
// - eret with mtc0 epc=0x80002000 in same cycle -> info=e; T+1 redirect_pc=0x80002000.
// - Stall: ri with mem_stall=1 for 3 cycles -> info=0; cycle stall drops -> info=a; flush one cycle later.
// - Back-to-back: exception at T and again at T+1/T+2 -> only one flush; second masked until HOLD ends.
// - rst asserted during FLUSH -> next cycle all outputs 0.

Source files
------------

// File: rtl/mem_except_ctrl_pkg.sv
// Shared constants for the MEM-stage exception controller: exception codes,
// CP0 register addresses, bus widths and controller state encoding.
package mem_except_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

  localparam logic [3:0] EXC_NONE = 4'h0;
  localparam logic [3:0] EXC_INT  = 4'h1;
  localparam logic [3:0] EXC_ADEL = 4'h4;
  localparam logic [3:0] EXC_ADES = 4'h5;
  localparam logic [3:0] EXC_SYS  = 4'h8;
  localparam logic [3:0] EXC_BP   = 4'h9;
  localparam logic [3:0] EXC_RI   = 4'hA;
  localparam logic [3:0] EXC_OV   = 4'hC;
  localparam logic [3:0] EXC_ERET = 4'hE;

  localparam logic [4:0] CP0_REG_EPC = 5'd14;

  localparam int unsigned CP0_BUS_W   = 96;
  localparam int unsigned W_CP0_BUS_W = 38;
  localparam int unsigned M_CP0_BUS_W = 69;

  localparam logic [1:0] BAD_NONE = 2'd0;
  localparam logic [1:0] BAD_PC   = 2'd1;
  localparam logic [1:0] BAD_DATA = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_HOLD
  } state_t;

  // Interrupt pending: IE set, not at exception level, some enabled line raised.
  function automatic logic int_pending(input logic [31:0] status, input logic [31:0] cause);
    return status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));
  endfunction

endpackage

// File: rtl/mem_except_ctrl_prio_enc.sv
// Combinational priority encoder: exception flags and interrupt state to a
// single exception code plus the source selector for the badaddr field.
module mem_except_ctrl_prio_enc
  import mem_except_ctrl_pkg::*;
(
  input  logic [6:0] exc_flags,
  input  logic       int_pend,
  input  logic       eret,
  output logic [3:0] code,
  output logic [1:0] badaddr_sel
);

  logic ov, ri, brk, sys, ades, adel_data, adel_fetch;

  assign {ov, ri, brk, sys, ades, adel_data, adel_fetch} = exc_flags;

  always_comb begin
    code        = EXC_NONE;
    badaddr_sel = BAD_NONE;
    if (int_pend) begin
      code = EXC_INT;
    end else if (adel_fetch) begin
      code        = EXC_ADEL;
      badaddr_sel = BAD_PC;
    end else if (ri) begin
      code = EXC_RI;
    end else if (ov) begin
      code = EXC_OV;
    end else if (sys) begin
      code = EXC_SYS;
    end else if (brk) begin
      code = EXC_BP;
    end else if (adel_data) begin
      code        = EXC_ADEL;
      badaddr_sel = BAD_DATA;
    end else if (ades) begin
      code        = EXC_ADES;
      badaddr_sel = BAD_DATA;
    end else if (eret) begin
      code = EXC_ERET;
    end
  end

endmodule

// File: rtl/mem_except_ctrl.sv
// MEM-stage exception controller: drives the CP0 exception bus, issues a
// one-cycle flush/redirect and masks re-entry while CP0 settles.
module mem_except_ctrl
  import mem_except_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_valid_i,
  input  logic                   mem_stall_i,
  input  logic [31:0]            mem_pc_i,
  input  logic                   mem_is_br_i,
  input  logic [6:0]             exc_flags_i,
  input  logic                   eret_i,
  input  logic [31:0]            mem_badaddr_i,
  input  logic [CP0_BUS_W-1:0]   cp0_bus_i,
  input  logic [W_CP0_BUS_W-1:0] w_cp0_bus_i,
  output logic [M_CP0_BUS_W-1:0] m_cp0_bus_o,
  output logic                   flush_o,
  output logic                   redirect_o,
  output logic [31:0]            redirect_pc_o
);

  localparam logic [1:0] HOLD_LOAD = 2'(HOLD_CYCLES);

  state_t      state, state_next;
  logic [1:0]  hold, hold_next;
  logic        br_q;
  logic [31:0] target_q;

  logic [31:0] status, cause, epc;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        int_pend;
  logic [3:0]  code;
  logic [1:0]  badaddr_sel;
  logic        commit;
  logic        take;
  logic [3:0]  except_info;
  logic [31:0] badaddr;
  logic [31:0] epc_src;
  logic        unused_bits;

  assign {status, cause, epc}     = cp0_bus_i;
  assign {w_en, w_addr, w_data}   = w_cp0_bus_i;
  assign int_pend                 = int_pending(status, cause);
  assign unused_bits = ^{status[31:16], status[7:2], cause[31:16], cause[7:0]};

  mem_except_ctrl_prio_enc u_prio_enc (
    .exc_flags   (exc_flags_i),
    .int_pend    (int_pend),
    .eret        (eret_i),
    .code        (code),
    .badaddr_sel (badaddr_sel)
  );

  assign commit      = mem_valid_i & ~mem_stall_i & (state == ST_RUN) & (hold == 2'd0);
  assign except_info = (commit & ~rst) ? code : EXC_NONE;
  assign take        = (except_info != EXC_NONE);

  // An mtc0 to EPC committing in the same cycle as eret must win over the stale CP0 copy.
  assign epc_src = (w_en && (w_addr == CP0_REG_EPC)) ? w_data : epc;

  always_comb begin
    badaddr = '0;
    case (badaddr_sel)
      BAD_PC:   badaddr = mem_pc_i;
      BAD_DATA: badaddr = mem_badaddr_i;
      default:  badaddr = '0;
    endcase
  end

  // The CP0 bus carries payload only when an exception is actually being raised.
  assign m_cp0_bus_o   = take ? {badaddr, br_q, mem_pc_i, except_info} : '0;
  assign flush_o       = (state == ST_FLUSH) & ~rst;
  assign redirect_o    = flush_o;
  assign redirect_pc_o = flush_o ? target_q : '0;

  always_comb begin
    state_next = state;
    hold_next  = hold;
    case (state)
      ST_RUN: begin
        if (take) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_next = ST_HOLD;
        hold_next  = HOLD_LOAD;
      end
      ST_HOLD: begin
        hold_next = (hold == 2'd0) ? 2'd0 : hold - 2'd1;
        if (hold_next == 2'd0) state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
        hold_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      hold     <= '0;
      br_q     <= 1'b0;
      target_q <= '0;
    end else begin
      state <= state_next;
      hold  <= hold_next;
      if (state == ST_FLUSH) begin
        br_q <= 1'b0;
      end else if (commit && !take) begin
        br_q <= mem_is_br_i;
      end
      if (take) begin
        target_q <= (code == EXC_ERET) ? epc_src : EXC_VECTOR;
      end
    end
  end

endmodule
